// File: rtl/imem_access_arbiter_pkg.sv
// Shared types and constants for the instruction-memory access arbiter.
// Holds the BOOT/RUN state encoding, memory depth and the word returned for out-of-range reads.
package imem_access_arbiter_pkg;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

    localparam int IMEM_DEPTH  = 65;
    localparam int IMEM_DATA_W = 32;

    localparam logic [IMEM_DATA_W-1:0] ZERO_WORD = '0;

    // Range check is done on the full 32-bit word index, so high address bits cannot alias.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/imem_starve_counter.sv
// Saturating counter that tracks how many consecutive cycles the loader has been denied.
// at_max_o tells the arbiter to force the loader through on the current cycle.
module imem_starve_counter #(
    parameter int MAX = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);

    localparam int CW = ($clog2(MAX + 1) > 0) ? $clog2(MAX + 1) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign at_max_o = (cnt_q == CW'(MAX));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !at_max_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_access_arbiter.sv
// Shares the single instruction-memory port between the fetch path and the loader/debug port.
// The loader owns the port during BOOT; in RUN fetch wins unless the loader has starved too long.
//
//   state   | meaning
//   ST_BOOT | program image being loaded; only the loader is served
//   ST_RUN  | normal operation; fetch priority with loader anti-starvation
module imem_access_arbiter
    import imem_access_arbiter_pkg::*;
#(
    parameter int DEPTH      = IMEM_DEPTH,
    parameter int DATA_W     = IMEM_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              fetch_req_i,
    input  logic [31:0]       fetch_addr_i,
    output logic              fetch_gnt_o,
    output logic              fetch_rvalid_o,
    output logic [DATA_W-1:0] fetch_rdata_o,
    input  logic              ldr_req_i,
    input  logic              ldr_we_i,
    input  logic [31:0]       ldr_addr_i,
    input  logic [DATA_W-1:0] ldr_wdata_i,
    input  logic              ldr_done_i,
    output logic              ldr_gnt_o,
    output logic              ldr_rvalid_o,
    output logic [DATA_W-1:0] ldr_rdata_o,
    output logic              addr_err_o,
    output logic              boot_done_o,
    output logic [31:0]       mem_ad_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wd_o,
    input  logic [DATA_W-1:0] mem_rd_i
);

    arb_state_e state_q;
    arb_state_e state_d;

    logic              fetch_gnt;
    logic              ldr_gnt;
    logic              ldr_rd_gnt;
    logic              any_gnt;
    logic              in_range;
    logic              starve_at_max;
    logic              starve_inc;
    logic              starve_clr;
    logic [DATA_W-1:0] rd_word;

    logic              fetch_rvalid_q;
    logic [DATA_W-1:0] fetch_rdata_q;
    logic              ldr_rvalid_q;
    logic [DATA_W-1:0] ldr_rdata_q;
    logic              addr_err_q;

    always_comb begin
        state_d = state_q;
        if ((state_q == ST_BOOT) && ldr_done_i) begin
            state_d = ST_RUN;
        end
    end

    always_comb begin
        fetch_gnt = 1'b0;
        ldr_gnt   = 1'b0;
        if (state_q == ST_BOOT) begin
            ldr_gnt = ldr_req_i;
        end else if (ldr_req_i && starve_at_max) begin
            ldr_gnt = 1'b1;
        end else begin
            fetch_gnt = fetch_req_i;
            ldr_gnt   = ldr_req_i & ~fetch_req_i;
        end
    end

    // In BOOT every loader request is granted, so the counter only ever advances in RUN.
    assign starve_inc = (state_q == ST_RUN) & ldr_req_i & ~ldr_gnt;
    assign starve_clr = ldr_gnt | ~ldr_req_i;

    imem_starve_counter #(
        .MAX(STARVE_MAX)
    ) u_starve (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (starve_inc),
        .clr_i   (starve_clr),
        .at_max_o(starve_at_max)
    );

    assign any_gnt    = fetch_gnt | ldr_gnt;
    assign ldr_rd_gnt = ldr_gnt & ~ldr_we_i;
    assign mem_ad_o   = fetch_gnt ? fetch_addr_i : (ldr_gnt ? ldr_addr_i : 32'h0);
    assign in_range   = addr_in_range(mem_ad_o, unsigned'(DEPTH));
    assign mem_we_o   = ldr_gnt & ldr_we_i & in_range;
    assign mem_wd_o   = ldr_wdata_i;
    assign rd_word    = in_range ? mem_rd_i : DATA_W'(ZERO_WORD);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= ST_BOOT;
            fetch_rvalid_q <= 1'b0;
            fetch_rdata_q  <= '0;
            ldr_rvalid_q   <= 1'b0;
            ldr_rdata_q    <= '0;
            addr_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            fetch_rvalid_q <= fetch_gnt;
            ldr_rvalid_q   <= ldr_rd_gnt;
            addr_err_q     <= any_gnt & ~in_range;
            if (fetch_gnt) begin
                fetch_rdata_q <= rd_word;
            end
            if (ldr_rd_gnt) begin
                ldr_rdata_q <= rd_word;
            end
        end
    end

    assign fetch_gnt_o    = fetch_gnt;
    assign ldr_gnt_o      = ldr_gnt;
    assign fetch_rvalid_o = fetch_rvalid_q;
    assign fetch_rdata_o  = fetch_rdata_q;
    assign ldr_rvalid_o   = ldr_rvalid_q;
    assign ldr_rdata_o    = ldr_rdata_q;
    assign addr_err_o     = addr_err_q;
    assign boot_done_o    = (state_q == ST_RUN);

endmodule
